beam_delay_sequencer: RTL and testbench

Controller that turns a steering-angle request into the per-mic delay table used by the delay-and-sum datapath. It accepts one request per valid/ready handshake, then walks the mic grid left-to-right, top-to-bottom. For each mic it issues paired reads to the dual-port mic-location ROM (1-cycle read latency), adds the horizontal and vertical delays with saturation, and stages the result in a shadow bank. It then commits the whole table to the datapath atomically, so the datapath never sees a partial table.

---
 rtl/beam_delay_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_beam_delay_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/beam_delay_sequencer.sv
// Beam delay sequencer: turns a steering-angle request into the per-mic delay table
// for the delay-and-sum datapath. Each accepted request sweeps the mic grid
// left-to-right, top-to-bottom. Every mic gets one paired read from the dual-port
// mic-location ROM. The horizontal and vertical delays are summed with saturation and
// staged in a shadow bank. The whole table is then committed to the active bank in one
// cycle, so the datapath never sees a half-built table.

module beam_delay_sequencer #(
  parameter int unsigned ANGLE_WIDTH    = 24,
  parameter int unsigned NUM_MICS       = 9,
  parameter int unsigned GRID_SIZE      = 3,
  parameter int unsigned ANGLE_STRIDE   = 28,
  parameter int unsigned ROM_ADDR_WIDTH = 9,
  parameter int unsigned ROM_DATA_WIDTH = 8,
  parameter int unsigned DELAY_WIDTH    = 10
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            steer_valid,
  output logic                            steer_ready,
  input  logic [ANGLE_WIDTH-1:0]          steer_hori,
  input  logic [ANGLE_WIDTH-1:0]          steer_vert,
  output logic                            rom_rden,
  output logic [ROM_ADDR_WIDTH-1:0]       rom_addr_a,
  output logic [ROM_ADDR_WIDTH-1:0]       rom_addr_b,
  input  logic [ROM_DATA_WIDTH-1:0]       rom_q_a,
  input  logic [ROM_DATA_WIDTH-1:0]       rom_q_b,
  output logic [NUM_MICS*DELAY_WIDTH-1:0] delays_flat,
  output logic                            delays_done,
  output logic                            delays_sat
);

  localparam int unsigned IDX_W = (GRID_SIZE > 1) ? $clog2(GRID_SIZE) : 1;
  localparam int unsigned MIC_W = (NUM_MICS > 1) ? $clog2(NUM_MICS) : 1;
  localparam int unsigned MAG_W = (ANGLE_STRIDE > 1) ? $clog2(ANGLE_STRIDE) : 1;
  localparam int unsigned AW1   = ANGLE_WIDTH + 1;
  localparam int unsigned SUM_W = ROM_DATA_WIDTH + 1;
  // Compare width is wide enough for both the raw sum and the delay ceiling.
  localparam int unsigned CMP_W = (DELAY_WIDTH > SUM_W) ? DELAY_WIDTH + 1 : SUM_W + 1;

  localparam logic [CMP_W-1:0] DELAY_MAX = {{(CMP_W - DELAY_WIDTH){1'b0}}, {DELAY_WIDTH{1'b1}}};

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSweep  = 2'd1;
  localparam logic [1:0] StDrain  = 2'd2;
  localparam logic [1:0] StCommit = 2'd3;

  // |angle| clamped to the last ROM column. The sign-extended form keeps the
  // most-negative angle from wrapping back to itself on negation.
  function automatic logic [MAG_W-1:0] angle_mag(input logic [ANGLE_WIDTH-1:0] angle);
    logic [AW1-1:0] ext;
    logic [AW1-1:0] abs_v;
    ext   = {angle[ANGLE_WIDTH-1], angle};
    abs_v = angle[ANGLE_WIDTH-1] ? (~ext + AW1'(1)) : ext;
    if (abs_v > AW1'(ANGLE_STRIDE - 1)) begin
      return MAG_W'(ANGLE_STRIDE - 1);
    end
    return abs_v[MAG_W-1:0];
  endfunction

  // Zero and negative angles walk the grid mirrored.
  function automatic logic angle_mirror(input logic [ANGLE_WIDTH-1:0] angle);
    return angle[ANGLE_WIDTH-1] || (angle == '0);
  endfunction

  function automatic logic [ROM_ADDR_WIDTH-1:0] table_addr(input logic [MAG_W-1:0] mag,
                                                           input logic             mirror,
                                                           input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] pos;
    pos = mirror ? (IDX_W'(GRID_SIZE - 1) - idx) : idx;
    return ROM_ADDR_WIDTH'(pos) * ROM_ADDR_WIDTH'(ANGLE_STRIDE) + ROM_ADDR_WIDTH'(mag);
  endfunction

  logic [1:0]                state_q, state_d;
  logic [MAG_W-1:0]          mag_h_q, mag_v_q;
  logic                      mir_h_q, mir_v_q;
  logic [IDX_W-1:0]          col_q, col_d;
  logic [IDX_W-1:0]          row_q, row_d;
  logic [MIC_W-1:0]          mic_q, mic_d;
  logic [ROM_ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
  logic [ROM_ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
  logic                      accept;
  logic                      mic_last;
  logic                      col_last;

  logic                      cap_valid_q;
  logic [MIC_W-1:0]          cap_idx_q;
  logic                      sat_q;
  logic [SUM_W-1:0]          sum;
  logic [CMP_W-1:0]          sum_ext;
  logic                      sum_over;
  logic [DELAY_WIDTH-1:0]    cap_delay;

  logic [DELAY_WIDTH-1:0]          shadow_q [NUM_MICS];
  logic [NUM_MICS*DELAY_WIDTH-1:0] flat_q;
  logic                            done_q;
  logic                            dsat_q;

  assign mic_last = (mic_q == MIC_W'(NUM_MICS - 1));
  assign col_last = (col_q == IDX_W'(GRID_SIZE - 1));

  // Sequencer next state: grid counters and the registered ROM address of the next mic.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    mic_d    = mic_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    accept   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (steer_valid) begin
          accept   = 1'b1;
          state_d  = StSweep;
          col_d    = '0;
          row_d    = '0;
          mic_d    = '0;
          // Mic 0 address comes straight from the inputs so it is on the bus next cycle.
          addr_a_d = table_addr(angle_mag(steer_hori), angle_mirror(steer_hori), '0);
          addr_b_d = table_addr(angle_mag(steer_vert), angle_mirror(steer_vert), '0);
        end
      end
      StSweep: begin
        if (mic_last) begin
          state_d = StDrain;
        end else begin
          if (col_last) begin
            col_d = '0;
            row_d = row_q + IDX_W'(1);
          end else begin
            col_d = col_q + IDX_W'(1);
          end
          mic_d    = mic_q + MIC_W'(1);
          addr_a_d = table_addr(mag_h_q, mir_h_q, col_d);
          addr_b_d = table_addr(mag_v_q, mir_v_q, row_d);
        end
      end
      StDrain:  state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Sequencer state, counters and ROM address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      col_q    <= '0;
      row_q    <= '0;
      mic_q    <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      mic_q    <= mic_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
    end
  end

  // Latch the decoded angles on accept so later input changes cannot disturb the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_h_q <= '0;
      mag_v_q <= '0;
      mir_h_q <= 1'b0;
      mir_v_q <= 1'b0;
    end else if (accept) begin
      mag_h_q <= angle_mag(steer_hori);
      mag_v_q <= angle_mag(steer_vert);
      mir_h_q <= angle_mirror(steer_hori);
      mir_v_q <= angle_mirror(steer_vert);
    end
  end

  // Saturating sum of the two ROM delays returned this cycle.
  always_comb begin
    sum       = SUM_W'(rom_q_a) + SUM_W'(rom_q_b);
    sum_ext   = CMP_W'(sum);
    sum_over  = (sum_ext > DELAY_MAX);
    cap_delay = sum_over ? {DELAY_WIDTH{1'b1}} : DELAY_WIDTH'(sum_ext);
  end

  // Track which mic's data arrives one cycle behind its address, and fold saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid_q <= 1'b0;
      cap_idx_q   <= '0;
      sat_q       <= 1'b0;
    end else begin
      cap_valid_q <= (state_q == StSweep);
      cap_idx_q   <= mic_q;
      if (accept) begin
        sat_q <= 1'b0;
      end else if (cap_valid_q && sum_over) begin
        sat_q <= 1'b1;
      end
    end
  end

  // Stage each mic's delay in the shadow bank as its ROM data lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_MICS; k++) begin
        shadow_q[k] <= '0;
      end
    end else if (cap_valid_q) begin
      shadow_q[cap_idx_q] <= cap_delay;
    end
  end

  // Atomic commit of the whole shadow table plus a one-cycle done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flat_q <= '0;
      done_q <= 1'b0;
      dsat_q <= 1'b0;
    end else begin
      done_q <= (state_q == StCommit);
      if (state_q == StCommit) begin
        for (int k = 0; k < NUM_MICS; k++) begin
          flat_q[k*DELAY_WIDTH +: DELAY_WIDTH] <= shadow_q[k];
        end
        dsat_q <= sat_q;
      end
    end
  end

  assign steer_ready = (state_q == StIdle);
  assign rom_rden    = (state_q == StSweep);
  assign rom_addr_a  = addr_a_q;
  assign rom_addr_b  = addr_b_q;
  assign delays_flat = flat_q;
  assign delays_done = done_q;
  assign delays_sat  = dsat_q;

endmodule

// File: tb/tb_beam_delay_sequencer.sv
// Scoreboard bench for beam_delay_sequencer. It runs with 8-bit delays so that
// saturation can be reached. A behavioural dual-port ROM model returns either its
// address or a constant.

module tb_beam_delay_sequencer;

  localparam int unsigned DW = 8;
  localparam int unsigned NM = 9;

  logic              clk;
  logic              rst_n;
  logic              steer_valid;
  logic              steer_ready;
  logic [23:0]       steer_hori;
  logic [23:0]       steer_vert;
  logic              rom_rden;
  logic [8:0]        rom_addr_a;
  logic [8:0]        rom_addr_b;
  logic [7:0]        rom_q_a;
  logic [7:0]        rom_q_b;
  logic [NM*DW-1:0]  delays_flat;
  logic              delays_done;
  logic              delays_sat;

  beam_delay_sequencer #(
    .ANGLE_WIDTH   (24),
    .NUM_MICS      (NM),
    .GRID_SIZE     (3),
    .ANGLE_STRIDE  (28),
    .ROM_ADDR_WIDTH(9),
    .ROM_DATA_WIDTH(8),
    .DELAY_WIDTH   (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .steer_valid(steer_valid),
    .steer_ready(steer_ready),
    .steer_hori (steer_hori),
    .steer_vert (steer_vert),
    .rom_rden   (rom_rden),
    .rom_addr_a (rom_addr_a),
    .rom_addr_b (rom_addr_b),
    .rom_q_a    (rom_q_a),
    .rom_q_b    (rom_q_b),
    .delays_flat(delays_flat),
    .delays_done(delays_done),
    .delays_sat (delays_sat)
  );

  typedef struct {
    logic [NM*DW-1:0] flat;
    logic             sat;
    int               cyc;
  } res_t;

  typedef struct {
    logic [8:0] a;
    logic [8:0] b;
  } addr_t;

  res_t             res_q[$];
  addr_t            addr_q[$];
  int               n_cmp;
  int               n_err;
  int               cyc;
  logic [NM*DW-1:0] last_flat;
  bit               rom_const_mode;
  logic [7:0]       rom_const;
  res_t             mon_r;
  addr_t            mon_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle-latency dual-port ROM model.
  always @(posedge clk) begin
    if (rom_rden) begin
      rom_q_a <= rom_const_mode ? rom_const : rom_addr_a[7:0];
      rom_q_b <= rom_const_mode ? rom_const : rom_addr_b[7:0];
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_addr(input logic signed [23:0] ang, input int idx);
    longint a;
    longint mag;
    int     pos;
    a   = ang;
    mag = (a < 0) ? -a : a;
    if (mag > 27) mag = 27;
    pos = (a > 0) ? idx : 2 - idx;
    return pos * 28 + int'(mag);
  endfunction

  // Issue one request; expectations are pushed in the cycle whose edge accepts it.
  task automatic send(input logic signed [23:0] h, input logic signed [23:0] v,
                      input bit cmode, input logic [7:0] cval, input bit hold);
    bit    got;
    res_t  r;
    addr_t e;
    int    aa, ab, qa, qb, s;
    @(negedge clk);
    steer_valid = 1'b1;
    steer_hori  = h;
    steer_vert  = v;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      if (steer_ready) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      chk("ready_timeout", steer_ready, 1);
    end else begin
      rom_const_mode = cmode;
      rom_const      = cval;
      r.flat = '0;
      r.sat  = 1'b0;
      r.cyc  = cyc + 12;
      for (int row = 0; row < 3; row++) begin
        for (int col = 0; col < 3; col++) begin
          aa  = exp_addr(h, col);
          ab  = exp_addr(v, row);
          e.a = 9'(aa);
          e.b = 9'(ab);
          addr_q.push_back(e);
          qa = cmode ? int'(cval) : (aa % 256);
          qb = cmode ? int'(cval) : (ab % 256);
          s  = qa + qb;
          if (s > 255) begin
            s     = 255;
            r.sat = 1'b1;
          end
          r.flat[(row*3+col)*DW +: DW] = 8'(s);
        end
      end
      res_q.push_back(r);
      @(posedge clk);
      #1;
      // Scramble the angles after accept; the sweep must not notice.
      steer_hori = 24'($urandom);
      steer_vert = 24'($urandom);
      if (!hold) steer_valid = 1'b0;
    end
  endtask

  // Scoreboard: pop address expectations on reads and table expectations on done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rom_rden) begin
        if (addr_q.size() == 0) begin
          chk("spurious_rden", rom_rden, 0);
        end else begin
          mon_a = addr_q.pop_front();
          chk("addr_a", rom_addr_a, mon_a.a);
          chk("addr_b", rom_addr_b, mon_a.b);
        end
      end
      if (delays_done) begin
        if (res_q.size() == 0) begin
          chk("spurious_done", delays_done, 0);
        end else begin
          mon_r = res_q.pop_front();
          chk("latency", cyc, mon_r.cyc);
          for (int k = 0; k < NM; k++) begin
            chk($sformatf("mic%0d", k), delays_flat[k*DW +: DW], mon_r.flat[k*DW +: DW]);
          end
          chk("sat", delays_sat, mon_r.sat);
          chk("ready_at_done", steer_ready, 1);
          last_flat = mon_r.flat;
        end
      end else begin
        chk("hold", delays_flat, last_flat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    cyc            = 0;
    last_flat      = '0;
    rom_const_mode = 1'b0;
    rom_const      = 8'h00;
    steer_valid    = 1'b0;
    steer_hori     = '0;
    steer_vert     = '0;
    rst_n          = 1'b0;

    #3;
    chk("rst_ready", steer_ready, 1);
    chk("rst_rden", rom_rden, 0);
    chk("rst_addr_a", rom_addr_a, 0);
    chk("rst_addr_b", rom_addr_b, 0);
    chk("rst_flat", delays_flat, 0);
    chk("rst_done", delays_done, 0);
    chk("rst_sat", delays_sat, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Address-mode tables: positive, mirrored, zero, clamped, most-negative.
    send(24'sd5, 24'sd3, 1'b0, 8'h00, 1'b0);
    send(-24'sd5, 24'sd3, 1'b0, 8'h00, 1'b0);
    send(24'sd0, 24'sd0, 1'b0, 8'h00, 1'b0);
    send(24'sd40, -24'sd7, 1'b0, 8'h00, 1'b0);
    send(24'sh800000, 24'sh7FFFFF, 1'b0, 8'h00, 1'b0);

    // Back-to-back with valid held: saturating table, clean table, then address mode.
    send(24'sd5, 24'sd3, 1'b1, 8'hC8, 1'b1);
    send(24'sd1, -24'sd2, 1'b1, 8'h10, 1'b1);
    send(24'sd7, -24'sd1, 1'b0, 8'h00, 1'b0);

    // Abort: reset in cycle 6 of a sweep.
    send(24'sd3, 24'sd4, 1'b0, 8'h00, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    res_q.delete();
    addr_q.delete();
    last_flat = '0;
    #1;
    chk("abort_flat", delays_flat, 0);
    chk("abort_ready", steer_ready, 1);
    chk("abort_rden", rom_rden, 0);
    chk("abort_addr_a", rom_addr_a, 0);
    chk("abort_done", delays_done, 0);
    chk("abort_sat", delays_sat, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_flat_after", delays_flat, 0);
    chk("abort_pending", res_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
